regs_multi: RTL
===============

REGS_MULTI -- requirements
Module: regs_multi

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter AW, default 5, address width; depth DEPTH = 2^AW entries.
REQ-003 Parameter NRD, default 2, number of read ports, legal range 1..4.
REQ-004 Parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-005 Parameter ZERO_REG, default 1: 1 = entry 0 reads as zero and is never written.
REQ-006 Port i_clk, input, 1, the single clock; all logic on the rising edge.
REQ-007 Port i_rst, input, 1, asynchronous active-high reset.
REQ-008 Port i_clr, input, 1, one-cycle pulse requesting a full-array clear.
REQ-009 Port i_hold, input, 1, freezes all read-data outputs.
REQ-010 Port i_addr_rd, input, NRD*AW, read addresses; port k occupies bits [k*AW +: AW].
REQ-011 Port i_we0, input, 1, write enable for write port 0.
REQ-012 Port i_addr_wr0, input, AW, write address for write port 0.
REQ-013 Port i_dat_wr0, input, XLEN, write data for write port 0.
REQ-014 Ports i_we1, i_addr_wr1, i_dat_wr1: same widths and meanings as port 0, for write port 1.
REQ-015 Port o_dat_rd, output, NRD*XLEN, registered read data; port k occupies bits [k*XLEN +: XLEN].
REQ-016 Port o_busy, output, 1, high while a clear sequence is in progress.

Function
REQ-017 Read latency: exactly 1 cycle; o_dat_rd[k] at edge N+1 reflects i_addr_rd[k] sampled at edge N.
REQ-018 i_hold=1: every o_dat_rd port keeps its value; writes and the clear sequence still proceed.
REQ-019 Write: when weX=1 and the FSM is IDLE, entry addr_wrX is updated at the clock edge.
REQ-020 ZERO_REG=1: writes to address 0 are dropped, and reads of address 0 return 0 regardless of bypass.
REQ-021 Both write ports enabled to the same address: port 1 data is stored; port 0 is discarded.
REQ-022 BYPASS=1: a read whose address matches an enabled, non-dropped write in the same cycle returns that write data; if both write ports match, port 1 data is returned.
REQ-023 BYPASS=0: such a read returns the pre-write contents.
REQ-024 FSM has two states, IDLE and CLEAR, plus an AW-bit clear index.
REQ-025 IDLE -> CLEAR on i_clr=1; the index is loaded with 0.
REQ-026 In CLEAR, one entry (the current index) is written with 0 per cycle and the index increments.
REQ-027 CLEAR -> IDLE on the cycle entry DEPTH-1 is cleared; o_busy is high for exactly DEPTH cycles.
REQ-028 The index wraps only at the end of the sequence; no entry is skipped or cleared twice.
REQ-029 In CLEAR: both write ports are ignored, i_clr is ignored (no restart), and o_dat_rd loads 0 unless i_hold=1.
REQ-030 i_clr and write enables asserted in the same IDLE cycle: the writes complete, then CLEAR starts on the next cycle and erases them.
REQ-031 o_busy is driven directly from a state register, with no combinational path from inputs.

Reset
REQ-032 i_rst=1 asynchronously forces state CLEAR, index 0, o_busy=1, and all o_dat_rd=0.
REQ-033 The array itself has no reset; it is zeroed by the CLEAR sequence, which starts on the first edge after i_rst deasserts.
REQ-034 i_rst asserted mid-CLEAR restarts the sequence from index 0 after deassertion.

Verification
REQ-035 Release reset -> o_busy=1 for 32 cycles (AW=5), then 0; read all 32 entries -> all 0.
REQ-036 Write 0xDEADBEEF to entry 7 via port 0, read entry 7 next cycle -> 0xDEADBEEF; write 0x1 to entry 0, read 0 -> 0.
REQ-037 Same cycle: port0 writes 0x11 and port1 writes 0x22 to entry 3, read entry 3 on both ports -> 0x22 with BYPASS=1; 0x22 on the following read with BYPASS=0.
REQ-038 Hold entry 5 = 0xA5, i_hold=1 for 3 cycles while changing i_addr_rd and writing entry 5 = 0x5A -> output stays 0xA5; release i_hold -> 0x5A.
REQ-039 Pulse i_clr, attempt a write to entry 9 during CLEAR -> busy for 32 cycles and entry 9 reads 0; pulse i_clr again at cycle 10 -> busy still ends at cycle 32.
REQ-040 Assert i_rst at clear cycle 15 for 2 cycles -> after deassertion busy lasts a full 32 cycles and every entry reads 0.

Source files
------------

// File: rtl/regs_multi.sv
// Multi-port register file: NRD registered read ports, two write ports, and a
// one-entry-per-cycle clear sequencer that also runs after reset.
module regs_multi #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clr,
    input  logic                  i_hold,
    input  logic [NRD*AW-1:0]     i_addr_rd,
    input  logic                  i_we0,
    input  logic [AW-1:0]         i_addr_wr0,
    input  logic [XLEN-1:0]       i_dat_wr0,
    input  logic                  i_we1,
    input  logic [AW-1:0]         i_addr_wr1,
    input  logic [XLEN-1:0]       i_dat_wr1,
    output logic [NRD*XLEN-1:0]   o_dat_rd,
    output logic                  o_busy
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state;
    logic [AW-1:0]       idx;
    logic [XLEN-1:0]     mem [DEPTH];
    logic                wr0_ok;
    logic                wr1_ok;
    logic [NRD*XLEN-1:0] rd_next;

    // A write is live only in IDLE, and never to the hard-wired zero entry.
    assign wr0_ok = i_we0 && (state == IDLE) && !((ZERO_REG != 0) && (i_addr_wr0 == '0));
    assign wr1_ok = i_we1 && (state == IDLE) && !((ZERO_REG != 0) && (i_addr_wr1 == '0));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= CLEAR;
            idx    <= '0;
            o_busy <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (i_clr) begin
                        state  <= CLEAR;
                        idx    <= '0;
                        o_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    idx <= idx + 1'b1;
                    if (idx == {AW{1'b1}}) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Port 1 is written last so it wins an address collision.
    always_ff @(posedge i_clk) begin
        if (state == CLEAR) begin
            mem[idx] <= '0;
        end else begin
            if (wr0_ok) mem[i_addr_wr0] <= i_dat_wr0;
            if (wr1_ok) mem[i_addr_wr1] <= i_dat_wr1;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] val;

        assign ra = i_addr_rd[k*AW +: AW];

        always_comb begin
            val = mem[ra];
            if (BYPASS != 0) begin
                if (wr0_ok && (i_addr_wr0 == ra)) val = i_dat_wr0;
                if (wr1_ok && (i_addr_wr1 == ra)) val = i_dat_wr1;
            end
            if ((ZERO_REG != 0) && (ra == '0)) val = '0;
            if (state == CLEAR) val = '0;
        end

        assign rd_next[k*XLEN +: XLEN] = val;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_dat_rd <= '0;
        end else if (!i_hold) begin
            o_dat_rd <= rd_next;
        end
    end

endmodule
